ysyx_22040931_if_stage: RTL and testbench
=========================================

// Module: ysyx_22040931_if_stage
// PURPOSE
// - Instruction-fetch stage directly upstream of the IF/ID pipeline register.
// - Owns the PC, issues one instruction-memory request at a time, and captures the response.
// - Does static branch prediction on the fetched word.
// - Presents pc/instr/prediction to IF/ID under a valid/ready handshake; handles EX-stage redirects.
// PARAMETERS
// - RESET_PC  64'h8000_0000  PC fetched first after reset
// - PC_W      64             PC / address width
// - INST_W    32             instruction width
// PORTS
// - clock            in   1       clock
// - reset            in   1       synchronous, active-high
// - redirect         in   1       EX mispredict / trap: refetch from redirect_pc
// - redirect_pc      in   PC_W    redirect target; bits [1:0] forced to 0
// - if_ready         in   1       IF/ID can accept this cycle
// - pc_valid         out  1       IF_* outputs hold a valid instruction
// - IF_pc            out  PC_W    PC of presented instruction
// - IF_instr         out  INST_W  presented instruction
// - IF_pre_jump      out  1       predicted taken
// - IF_pre_branch    out  PC_W    predicted next PC (target if taken, else pc+4)
// - imem_req_valid   out  1       fetch request
// - imem_req_ready   in   1       memory accepts request
// - imem_req_addr    out  PC_W    fetch address
// - imem_resp_valid  in   1       fetch data valid (exactly one per accepted request)
// - imem_resp_data   in   INST_W  fetched word
// BEHAVIOUR
// - Reset values:
//   - pc = RESET_PC; state = REQ.
//   - pc_valid, IF_pc, IF_instr, IF_pre_jump, IF_pre_branch all 0.
//   - imem_req_valid = 0 in the reset cycle.
// - FSM states: REQ, WAIT, VALID, KILL. At most one request outstanding.
//   - REQ:   imem_req_valid = 1, imem_req_addr = pc (stable until accepted). req_ready -> WAIT.
//   - WAIT:  resp_valid -> register pc / resp_data / prediction into IF_*; -> VALID.
//   - VALID: pc_valid = 1; IF_* frozen while !if_ready.
//            if_ready -> pc <= IF_pre_branch; pc_valid = 0 next cycle; -> REQ.
//   - KILL:  waits for the stale response. resp_valid -> discard; -> REQ.
// - Latency (1-cycle memory): request accepted at t, resp at t+1, pc_valid at t+2.
//   Next request at t+3 after handoff. Peak rate is 1 instruction per 3 cycles.
// - Prediction, combinational on resp_data, registered with it:
//   - JAL (opcode 1101111): taken, target = pc + sext(J-imm).
//   - B-type (opcode 1100011) with instr[31] = 1 (backward): taken, target = pc + sext(B-imm).
//   - Everything else, including JALR: not taken, IF_pre_branch = pc + 4.
//   - All adds are modulo 2^PC_W; wrap-around is not flagged.
// - Redirect has top priority; new pc <= {redirect_pc[PC_W-1:2], 2'b00}:
//   - REQ, request not accepted: stay REQ, new address from next cycle.
//   - REQ with req_ready in the same cycle: -> KILL (in-flight response is stale).
//   - WAIT, no resp: -> KILL. WAIT with resp in the same cycle: discard resp; -> REQ.
//   - VALID: drop the instruction, pc_valid = 0 next cycle; -> REQ.
//     Redirect wins over a simultaneous if_ready handoff.
//   - KILL: update pc. Stay KILL unless resp_valid arrives the same cycle, then -> REQ.
// - A discarded response never reaches IF_*. Reset mid-transaction returns to reset state.
//   The memory side must be reset with the stage.
// TESTING
// - Reset, 1-cycle imem, if_ready = 1:
//   -> first imem_req_addr = 0x8000_0000; pc_valid at cycle 3; IF_pre_branch = 0x8000_0004.
// - Word 0x0100006F (jal x0,+16) at 0x8000_0000:
//   -> IF_pre_jump = 1, IF_pre_branch = 0x8000_0010; next req addr 0x8000_0010.
// - Word 0xFE000CE3 (beq -8) at 0x8000_0010:
//   -> IF_pre_jump = 1, IF_pre_branch = 0x8000_0008.
// - if_ready = 0 for 5 cycles in VALID:
//   -> IF_* stable, no new imem request; handoff on the first if_ready.
// - redirect to 0x8000_0103 while WAIT, 3-cycle imem latency:
//   -> stale resp dropped, pc_valid stays 0; next req addr 0x8000_0100.
// - redirect and if_ready together in VALID:
//   -> pc_valid = 0 next cycle; next req addr = redirect target.

Source files
------------

// File: rtl/ysyx_22040931_if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight, statically predicts the fetched word and hands pc/instr/prediction
// to IF/ID under a valid/ready handshake. EX redirects take top priority.
module ysyx_22040931_if_stage #(
  parameter int unsigned         PC_W     = 64,
  parameter int unsigned         INST_W   = 32,
  parameter logic [PC_W-1:0]     RESET_PC = 64'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              if_ready,
  output logic              pc_valid,
  output logic [PC_W-1:0]   IF_pc,
  output logic [INST_W-1:0] IF_instr,
  output logic              IF_pre_jump,
  output logic [PC_W-1:0]   IF_pre_branch,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_VALID,
    ST_KILL
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            capture;

  logic [PC_W-1:0] redirect_tgt;
  logic [6:0]      opcode;
  logic            is_jal, is_bwd_branch;
  logic [PC_W-1:0] j_imm, b_imm;
  logic            pred_jump;
  logic [PC_W-1:0] pred_target;

  assign redirect_tgt = {redirect_pc[PC_W-1:2], 2'b00};

  // Static prediction on the raw response word; registered together with it.
  always_comb begin
    opcode        = imem_resp_data[6:0];
    is_jal        = (opcode == 7'b1101111);
    is_bwd_branch = (opcode == 7'b1100011) && imem_resp_data[31];
    j_imm = {{(PC_W-21){imem_resp_data[31]}}, imem_resp_data[31], imem_resp_data[19:12],
             imem_resp_data[20], imem_resp_data[30:21], 1'b0};
    b_imm = {{(PC_W-13){imem_resp_data[31]}}, imem_resp_data[31], imem_resp_data[7],
             imem_resp_data[30:25], imem_resp_data[11:8], 1'b0};
    pred_jump = is_jal || is_bwd_branch;
    if (is_jal)
      pred_target = pc + j_imm;
    else if (is_bwd_branch)
      pred_target = pc + b_imm;
    else
      pred_target = pc + PC_W'(4);
  end

  // Next-state / next-pc; redirect overrides every other transition.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    unique case (state)
      ST_REQ: begin
        if (redirect) pc_nxt = redirect_tgt;
        // An accepted request under redirect still returns a response: drain it.
        if (imem_req_ready) state_nxt = redirect ? ST_KILL : ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_nxt    = redirect_tgt;
          state_nxt = imem_resp_valid ? ST_REQ : ST_KILL;
        end else if (imem_resp_valid) begin
          capture   = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          pc_nxt    = redirect_tgt;
          state_nxt = ST_REQ;
        end else if (if_ready) begin
          pc_nxt    = IF_pre_branch;
          state_nxt = ST_REQ;
        end
      end
      ST_KILL: begin
        if (redirect) pc_nxt = redirect_tgt;
        if (imem_resp_valid) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  // State, PC and the IF/ID-facing capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_REQ;
      pc            <= RESET_PC;
      IF_pc         <= '0;
      IF_instr      <= '0;
      IF_pre_jump   <= 1'b0;
      IF_pre_branch <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        IF_pc         <= pc;
        IF_instr      <= imem_resp_data;
        IF_pre_jump   <= pred_jump;
        IF_pre_branch <= pred_target;
      end
    end
  end

  assign pc_valid       = (state == ST_VALID);
  assign imem_req_valid = (state == ST_REQ) && !reset;
  assign imem_req_addr  = pc;

endmodule

// File: tb/tb_ysyx_22040931_if_stage.sv
// Bench for the fetch stage: behavioural imem with programmable latency,
// constant-valued scoreboard of expected handoffs, one task per scenario.
module tb_ysyx_22040931_if_stage;

  logic        clock = 1'b0;
  logic        reset, redirect, if_ready;
  logic [63:0] redirect_pc;
  logic        pc_valid, IF_pre_jump;
  logic [63:0] IF_pc, IF_pre_branch;
  logic [31:0] IF_instr;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_resp_data;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        jump;
    logic [63:0] br;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mem_lat = 1;

  ysyx_22040931_if_stage #(.PC_W(64), .INST_W(32), .RESET_PC(64'h8000_0000)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_ready(if_ready), .pc_valid(pc_valid), .IF_pc(IF_pc), .IF_instr(IF_instr),
    .IF_pre_jump(IF_pre_jump), .IF_pre_branch(IF_pre_branch),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0100_006F; // jal x0,+16
      64'h8000_0008: return 32'h0000_80E7; // jalr x1,0(x1)
      64'h8000_000C: return 32'h0000_0463; // beq x0,x0,+8 (forward)
      64'h8000_0010: return 32'hFE00_0CE3; // beq -8 (backward)
      default:       return 32'h0000_0013; // nop
    endcase
  endfunction

  // imem model: samples at negedge, response valid mem_lat cycles after accept.
  initial begin : imem_model
    int unsigned cnt;
    logic [63:0] pend;
    cnt = 0; pend = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        cnt = 0; imem_resp_valid = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt = cnt - 1;
          imem_resp_valid = (cnt == 0);
          imem_resp_data  = (cnt == 0) ? mem_word(pend) : 32'h0;
        end else begin
          imem_resp_valid = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          pend = imem_req_addr; cnt = mem_lat;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] w, input logic j,
                      input logic [63:0] br);
    exp_t e;
    e.pc = pc; e.instr = w; e.jump = j; e.br = br;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0; mem_lat = 1;
    @(negedge clock);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
    step(); @(negedge clock);
    n_cmp++; if (pc_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_pc_valid got=%b want=0", pc_valid); end
    n_cmp++; if ({IF_pc, IF_instr, IF_pre_jump, IF_pre_branch} !== 161'h0) begin n_bad++;
      $display("FAIL reset_if_regs got=%h want=0", {IF_pc, IF_instr, IF_pre_jump, IF_pre_branch}); end
    step(); reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin n_bad++;
      $display("FAIL first_req got=%b/%h want=1/80000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stream();
    int hand = 0, cyc = 0, prev = 0;
    bit want_req = 0;
    logic [63:0] want_addr = '0;
    exp_t e;
    push(64'h8000_0000, 32'h0100_006F, 1'b1, 64'h8000_0010);
    push(64'h8000_0010, 32'hFE00_0CE3, 1'b1, 64'h8000_0008);
    push(64'h8000_0008, 32'h0000_80E7, 1'b0, 64'h8000_000C);
    push(64'h8000_000C, 32'h0000_0463, 1'b0, 64'h8000_0010);
    push(64'h8000_0010, 32'hFE00_0CE3, 1'b1, 64'h8000_0008);
    if_ready = 1'b1;
    while ((hand < 5 || want_req) && cyc < 60) begin
      step(); @(negedge clock); cyc++;
      if (want_req) begin
        want_req = 0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== want_addr) begin n_bad++;
          $display("FAIL stream_next_req got=%b/%h want=1/%h", imem_req_valid, imem_req_addr, want_addr); end
      end
      if (pc_valid && if_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL stream_unexpected pc=%h", IF_pc);
        end else begin
          e = sb.pop_front();
          n_cmp++; if ({IF_pc, IF_instr, IF_pre_jump, IF_pre_branch} !== {e.pc, e.instr, e.jump, e.br}) begin
            n_bad++; $display("FAIL stream_handoff got=%h/%h/%b/%h want=%h/%h/%b/%h",
              IF_pc, IF_instr, IF_pre_jump, IF_pre_branch, e.pc, e.instr, e.jump, e.br); end
          want_req = 1; want_addr = e.br;
        end
        n_cmp++;
        if (hand == 0) begin
          if (cyc != 2) begin n_bad++; $display("FAIL first_valid_latency got=%0d want=2", cyc); end
        end else if (cyc - prev != 3) begin
          n_bad++; $display("FAIL stream_rate got=%0d want=3", cyc - prev);
        end
        prev = cyc; hand++;
      end
    end
    n_cmp++; if (hand != 5) begin n_bad++; $display("FAIL stream_timeout got=%0d want=5", hand); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit seen = 0;
    push(64'h8000_0008, 32'h0000_80E7, 1'b0, 64'h8000_000C);
    e = sb[sb.size()-1];
    step(); if_ready = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (pc_valid) seen = 1; else step();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_timeout got=0 want=1"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step(); @(negedge clock); end
      n_cmp++; if (pc_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_bad++;
        $display("FAIL bp_hold got=%b/%b want=1/0", pc_valid, imem_req_valid); end
      n_cmp++; if ({IF_pc, IF_instr, IF_pre_jump, IF_pre_branch} !== {e.pc, e.instr, e.jump, e.br}) begin
        n_bad++; $display("FAIL bp_hold_data got=%h/%h want=%h/%h", IF_pc, IF_pre_branch, e.pc, e.br); end
    end
    step(); if_ready = 1'b1;
    @(negedge clock);
    e = sb.pop_front();
    n_cmp++; if (pc_valid !== 1'b1 || {IF_pc, IF_instr, IF_pre_jump, IF_pre_branch} !== {e.pc, e.instr, e.jump, e.br}) begin
      n_bad++; $display("FAIL bp_handoff got=%b/%h want=1/%h", pc_valid, IF_pc, e.pc); end
    step(); @(negedge clock);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_000C) begin n_bad++;
      $display("FAIL bp_next_req got=%b/%h want=1/8000000c", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    exp_t e;
    bit seen = 0;
    step(); mem_lat = 3;
    push(64'h8000_000C, 32'h0000_0463, 1'b0, 64'h8000_0010);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (pc_valid && if_ready) begin
        seen = 1; e = sb.pop_front();
        n_cmp++; if ({IF_pc, IF_instr, IF_pre_jump, IF_pre_branch} !== {e.pc, e.instr, e.jump, e.br}) begin
          n_bad++; $display("FAIL rw_handoff got=%h/%h want=%h/%h", IF_pc, IF_instr, e.pc, e.instr); end
      end else step();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rw_handoff_timeout got=0 want=1"); end
    step(); @(negedge clock);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0010) begin n_bad++;
      $display("FAIL rw_req got=%b/%h want=1/80000010", imem_req_valid, imem_req_addr); end
    step(); redirect = 1'b1; redirect_pc = 64'h8000_0103;
    @(negedge clock);
    n_cmp++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid_low got=%b want=0", pc_valid); end
    step(); redirect = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      n_cmp++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL rw_no_stale got=%b want=0", pc_valid); end
      if (imem_req_valid) seen = 1; else step();
    end
    n_cmp++; if (!seen || imem_req_addr !== 64'h8000_0100) begin n_bad++;
      $display("FAIL rw_redirect_addr got=%b/%h want=1/80000100", seen, imem_req_addr); end
  endtask

  task automatic test_redirect_valid();
    bit seen = 0;
    step(); if_ready = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (pc_valid) seen = 1; else step();
    end
    n_cmp++; if (!seen || IF_pc !== 64'h8000_0100 || IF_pre_branch !== 64'h8000_0104) begin n_bad++;
      $display("FAIL rv_valid got=%b/%h/%h want=1/80000100/80000104", seen, IF_pc, IF_pre_branch); end
    step(); redirect = 1'b1; if_ready = 1'b1; redirect_pc = 64'h8000_0008;
    @(negedge clock);
    step(); redirect = 1'b0;
    @(negedge clock);
    n_cmp++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL rv_valid_drop got=%b want=0", pc_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008) begin n_bad++;
      $display("FAIL rv_req_addr got=%b/%h want=1/80000008", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    bit seen = 0;
    step(); reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL mid_reset_req got=%b want=0", imem_req_valid); end
    step(); reset = 1'b0; mem_lat = 1;
    @(negedge clock);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000 || pc_valid !== 1'b0) begin n_bad++;
      $display("FAIL mid_reset_restart got=%b/%h/%b want=1/80000000/0", imem_req_valid, imem_req_addr, pc_valid); end
    push(64'h8000_0000, 32'h0100_006F, 1'b1, 64'h8000_0010);
    for (int i = 0; i < 10 && !seen; i++) begin
      step(); @(negedge clock);
      if (pc_valid && if_ready) begin
        seen = 1; e = sb.pop_front();
        n_cmp++; if ({IF_pc, IF_instr, IF_pre_jump, IF_pre_branch} !== {e.pc, e.instr, e.jump, e.br}) begin
          n_bad++; $display("FAIL mid_reset_handoff got=%h/%h want=%h/%h", IF_pc, IF_instr, e.pc, e.instr); end
      end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_reset_timeout got=0 want=1"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_valid();
    test_reset_midflight();
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
